dds_phase_streamer: RTL and testbench

Phase-accumulator and output stage of the DDS, directly downstream of the sampling clock divider. Each time the divider's sample-enable pulse arrives, the block advances a phase accumulator by the frequency tuning word and pushes the offset, truncated phase word into a small FIFO. The FIFO drains over an AXI4-Stream master to the waveform LUT or DAC path. Samples that arrive while the FIFO is full are dropped and counted; the timebase is never stalled.

---
 rtl/dds_pkg.sv | 13 +
 rtl/dds_sample_fifo.sv | 59 +++++
 rtl/dds_phase_streamer.sv | 91 +++++++++
 tb/tb_dds_phase_streamer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared DDS constants and types: control-register bit positions (also used by
// the clock divider) and default datapath widths.
package dds_pkg;

   localparam int DDS_CTRL_RST_BIT  = 0;
   localparam int DDS_CTRL_STRT_BIT = 1;
   localparam int DDS_PHASE_W       = 32;
   localparam int DDS_OUT_W         = 16;

   typedef logic [DDS_PHASE_W-1:0] phase_t;
   typedef logic [DDS_OUT_W-1:0]   sample_t;

endpackage

// File: rtl/dds_sample_fifo.sv
// Small synchronous FIFO for phase samples. A push into a full FIFO is accepted
// when a pop happens on the same edge; there is no empty-FIFO bypass.
module dds_sample_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         a_rst_n,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [W-1:0]                 din,
   output logic [W-1:0]                 dout,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!a_rst_n || clr) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer widths equal log2(DEPTH), so increments wrap modulo DEPTH.
   always_ff @(posedge clk) begin
      if (!a_rst_n || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/dds_phase_streamer.sv
// DDS phase accumulator with offset, sample FIFO and AXI4-Stream output.
// Samples arriving into a full FIFO are dropped and counted; the timebase never stalls.
module dds_phase_streamer
   import dds_pkg::*;
#(
   parameter int PHASE_W       = DDS_PHASE_W,
   parameter int OUT_W         = DDS_OUT_W,
   parameter int FIFO_DEPTH    = 4,
   parameter int CTRL_RST_BIT  = DDS_CTRL_RST_BIT,
   parameter int CTRL_STRT_BIT = DDS_CTRL_STRT_BIT
) (
   input  logic              clk,
   input  logic              a_rst_n,
   input  logic              i_ckdivider_sample_en,
   input  logic [31:0]       i_dds_ftw_reg,
   input  logic [31:0]       i_dds_phase_off_reg,
   input  logic [31:0]       i_dds_ctrl_reg,
   output logic [OUT_W-1:0]  o_dds_tdata,
   output logic              o_dds_tvalid,
   input  logic              i_dds_tready,
   output logic              o_dds_ovf,
   output logic [15:0]       o_dds_drop_cnt
);

   localparam int OCC_W = $clog2(FIFO_DEPTH+1);

   logic [PHASE_W-1:0] acc;
   logic [PHASE_W-1:0] phase_sum;
   logic [OUT_W-1:0]   sample;
   logic               soft_rst;
   logic               run;
   logic               sample_evt;
   logic               pop;
   logic               push;
   logic               drop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [OCC_W-1:0]   occ;
   logic               unused_regs;

   assign unused_regs = ^{i_dds_ctrl_reg, i_dds_ftw_reg, i_dds_phase_off_reg};

   assign soft_rst   = i_dds_ctrl_reg[CTRL_RST_BIT];
   assign run        = i_dds_ctrl_reg[CTRL_STRT_BIT];
   assign sample_evt = run && i_ckdivider_sample_en && !soft_rst;

   assign phase_sum  = acc + i_dds_phase_off_reg[PHASE_W-1:0];
   assign sample     = phase_sum[PHASE_W-1 -: OUT_W];

   // tvalid comes only from registered occupancy, never from tready.
   assign o_dds_tvalid = (occ != '0);
   assign pop          = !fifo_empty && i_dds_tready;
   assign push         = sample_evt && (!fifo_full || pop);
   assign drop         = sample_evt && fifo_full && !pop;

   // The accumulator advances on every sample event, dropped or not.
   always_ff @(posedge clk) begin
      if (!a_rst_n || soft_rst) begin
         acc <= '0;
      end else if (sample_evt) begin
         acc <= acc + i_dds_ftw_reg[PHASE_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!a_rst_n || soft_rst) begin
         o_dds_ovf      <= 1'b0;
         o_dds_drop_cnt <= '0;
      end else if (drop) begin
         o_dds_ovf <= 1'b1;
         if (o_dds_drop_cnt != 16'hFFFF) o_dds_drop_cnt <= o_dds_drop_cnt + 16'd1;
      end
   end

   dds_sample_fifo #(
      .W     (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .a_rst_n (a_rst_n),
      .clr     (soft_rst),
      .push    (push),
      .pop     (pop),
      .din     (sample),
      .dout    (o_dds_tdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (occ)
   );

endmodule

// File: tb/tb_dds_phase_streamer.sv
// Scoreboard bench for dds_phase_streamer: a behavioural model pushes expected
// samples into a queue; the DUT output is compared whenever a transfer occurs.
module tb_dds_phase_streamer;
   import dds_pkg::*;

   logic        clk = 1'b0;
   logic        a_rst_n;
   logic        i_ckdivider_sample_en;
   logic [31:0] i_dds_ftw_reg;
   logic [31:0] i_dds_phase_off_reg;
   logic [31:0] i_dds_ctrl_reg;
   logic [15:0] o_dds_tdata;
   logic        o_dds_tvalid;
   logic        i_dds_tready;
   logic        o_dds_ovf;
   logic [15:0] o_dds_drop_cnt;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b1;

   sample_t     exp_q[$];
   logic [31:0] m_acc;
   logic [31:0] m_sum;
   logic        m_ovf;
   logic [15:0] m_drop;

   always #5 clk = ~clk;

   dds_phase_streamer dut (
      .clk                   (clk),
      .a_rst_n               (a_rst_n),
      .i_ckdivider_sample_en (i_ckdivider_sample_en),
      .i_dds_ftw_reg         (i_dds_ftw_reg),
      .i_dds_phase_off_reg   (i_dds_phase_off_reg),
      .i_dds_ctrl_reg        (i_dds_ctrl_reg),
      .o_dds_tdata           (o_dds_tdata),
      .o_dds_tvalid          (o_dds_tvalid),
      .i_dds_tready          (i_dds_tready),
      .o_dds_ovf             (o_dds_ovf),
      .o_dds_drop_cnt        (o_dds_drop_cnt)
   );

   task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model, evaluated on the same edge as the DUT.
   always @(posedge clk) begin
      if (!a_rst_n || i_dds_ctrl_reg[0]) begin
         m_acc  = '0;
         m_ovf  = 1'b0;
         m_drop = '0;
         exp_q.delete();
      end else begin
         if (exp_q.size() != 0 && i_dds_tready) void'(exp_q.pop_front());
         if (i_dds_ctrl_reg[1] && i_ckdivider_sample_en) begin
            m_sum = m_acc + i_dds_phase_off_reg;
            if (exp_q.size() < 4) begin
               exp_q.push_back(m_sum[31:16]);
            end else begin
               m_ovf = 1'b1;
               if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            m_acc = m_acc + i_dds_ftw_reg;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en && a_rst_n) begin
         check_val("tvalid", o_dds_tvalid, exp_q.size() != 0);
         check_val("ovf", o_dds_ovf, m_ovf);
         check_val("drop_cnt", o_dds_drop_cnt, m_drop);
         if (exp_q.size() != 0 && i_dds_tready) check_val("tdata", o_dds_tdata, exp_q[0]);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic strobes(int n, int gap);
      for (int k = 0; k < n; k++) begin
         i_ckdivider_sample_en = 1'b1;
         step();
         i_ckdivider_sample_en = 1'b0;
         repeat (gap - 1) step();
      end
   endtask

   initial begin
      a_rst_n               = 1'b0;
      i_ckdivider_sample_en = 1'b0;
      i_dds_ftw_reg         = '0;
      i_dds_phase_off_reg   = '0;
      i_dds_ctrl_reg        = '0;
      i_dds_tready          = 1'b0;
      repeat (3) step();
      a_rst_n = 1'b1;
      check_val("rst_tvalid", o_dds_tvalid, 0);
      check_val("rst_tdata", o_dds_tdata, 0);
      check_val("rst_ovf", o_dds_ovf, 0);
      check_val("rst_drop", o_dds_drop_cnt, 0);

      // basic ramp, wraps after 16 samples
      i_dds_ftw_reg  = 32'h1000_0000;
      i_dds_ctrl_reg = 32'h2;
      i_dds_tready   = 1'b1;
      i_ckdivider_sample_en = 1'b1;
      step();
      i_ckdivider_sample_en = 1'b0;
      check_val("ramp_first_valid", o_dds_tvalid, 1);
      check_val("ramp_first_data", o_dds_tdata, 16'h0000);
      repeat (3) step();
      strobes(16, 4);
      step();

      // offset and wrap
      i_dds_ctrl_reg = 32'h1;
      step();
      i_dds_ctrl_reg      = 32'h2;
      i_dds_ftw_reg       = 32'h8000_0000;
      i_dds_phase_off_reg = 32'hC000_0000;
      strobes(4, 2);
      step();

      // backpressure and drop
      i_dds_ctrl_reg = 32'h1;
      step();
      i_dds_ctrl_reg      = 32'h2;
      i_dds_ftw_reg       = 32'h0001_0000;
      i_dds_phase_off_reg = 32'h0;
      i_dds_tready        = 1'b0;
      i_ckdivider_sample_en = 1'b1;
      repeat (6) step();
      i_ckdivider_sample_en = 1'b0;
      check_val("bp_drop_cnt", o_dds_drop_cnt, 2);
      check_val("bp_ovf", o_dds_ovf, 1);
      check_val("bp_head", o_dds_tdata, 16'h0000);
      i_dds_tready = 1'b1;
      repeat (5) step();
      i_ckdivider_sample_en = 1'b1;
      step();
      i_ckdivider_sample_en = 1'b0;
      check_val("bp_next", o_dds_tdata, 16'h0006);
      repeat (2) step();

      // full FIFO with simultaneous pop: accepted, then a further push must drop
      i_dds_tready = 1'b0;
      strobes(4, 1);
      check_val("full_valid", o_dds_tvalid, 1);
      i_dds_tready = 1'b1;
      i_ckdivider_sample_en = 1'b1;
      step();
      i_dds_tready = 1'b0;
      check_val("full_pop_nodrop", o_dds_drop_cnt, 2);
      step();
      i_ckdivider_sample_en = 1'b0;
      check_val("full_still4", o_dds_drop_cnt, 3);
      i_dds_tready = 1'b1;
      repeat (6) step();

      // run=0 holds the accumulator, then soft reset with data queued
      strobes(3, 2);
      i_dds_ctrl_reg = 32'h0;
      i_ckdivider_sample_en = 1'b1;
      repeat (10) step();
      i_ckdivider_sample_en = 1'b0;
      check_val("norun_empty", o_dds_tvalid, 0);
      i_dds_ctrl_reg = 32'h2;
      strobes(2, 2);
      i_dds_tready = 1'b0;
      strobes(2, 1);
      i_dds_ctrl_reg        = 32'h3;
      i_dds_phase_off_reg   = 32'h1234_0000;
      i_ckdivider_sample_en = 1'b1;
      step();
      i_ckdivider_sample_en = 1'b0;
      i_dds_ctrl_reg        = 32'h2;
      check_val("srst_tvalid", o_dds_tvalid, 0);
      check_val("srst_drop", o_dds_drop_cnt, 0);
      check_val("srst_ovf", o_dds_ovf, 0);
      i_dds_tready = 1'b1;
      i_ckdivider_sample_en = 1'b1;
      step();
      i_ckdivider_sample_en = 1'b0;
      check_val("srst_first", o_dds_tdata, 16'h1234);
      repeat (2) step();

      // drop counter saturation
      chk_en       = 1'b0;
      i_dds_tready = 1'b0;
      i_ckdivider_sample_en = 1'b1;
      repeat (4 + 65534) step();
      check_val("sat_fffe", o_dds_drop_cnt, 16'hFFFE);
      step();
      check_val("sat_ffff", o_dds_drop_cnt, 16'hFFFF);
      repeat (5) step();
      check_val("sat_hold", o_dds_drop_cnt, 16'hFFFF);
      i_ckdivider_sample_en = 1'b0;
      i_dds_ctrl_reg        = 32'h0;
      repeat (3) step();
      check_val("sat_ovf", o_dds_ovf, 1);
      a_rst_n = 1'b0;
      step();
      a_rst_n = 1'b1;
      chk_en  = 1'b1;
      check_val("end_ovf", o_dds_ovf, 0);
      check_val("end_drop", o_dds_drop_cnt, 0);
      check_val("end_tvalid", o_dds_tvalid, 0);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
